// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_types_pkg : shared CPU datapath types (mux selects, memory-stage state)
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_LUI = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      PC_NEXT   = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_JR     = 2'd3
   } pc_sel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      DONE   = 2'd2,
      HALTED = 2'd3
   } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones; clear has priority
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_req_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_req_unit : MEM-stage data-cache request controller with halt and stall
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_req_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dREN_i,
   input  logic              dWEN_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] store_i,
   input  logic              halt_i,
   input  logic              hold_i,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic [WORD_W-1:0] dload_o,
   output logic              mem_stall,
   output logic              halt_o,
   output logic [CNT_W-1:0]  wait_cnt
);

   mem_state_t        r_state;
   mem_state_t        w_next;
   logic [WORD_W-1:0] r_ld_q;
   logic              r_halt;
   logic              w_active;
   logic              w_req;
   logic              w_miss;

   assign w_active  = (r_state == IDLE) || (r_state == WAIT);
   assign w_req     = w_active && (dREN_i || dWEN_i);
   assign w_miss    = w_req && !dhit;

   // Store wins when both enables are high.
   assign dmemWEN   = w_active && dWEN_i;
   assign dmemREN   = w_active && dREN_i && !dWEN_i;
   assign dmemaddr  = addr_i;
   assign dmemstore = store_i;
   assign dload_o   = w_active ? dmemload : r_ld_q;
   assign mem_stall = w_miss || hold_i;
   assign halt_o    = r_halt;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, WAIT: begin
            if (w_req) begin
               if (!dhit)       w_next = WAIT;
               else if (hold_i) w_next = DONE;
               else             w_next = IDLE;
            end else if (halt_i) begin
               w_next = HALTED;
            end else begin
               w_next = IDLE;
            end
         end
         DONE:    if (!hold_i) w_next = IDLE;
         HALTED:  w_next = HALTED;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_ld_q  <= '0;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         // Hit under hold: keep the data alive until MEM/WB can take it.
         if (w_req && dhit && hold_i) r_ld_q <= dmemload;
         if (r_state == HALTED)       r_halt <= 1'b1;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_wait_cnt (
      .clk   (CLK),
      .rst   (RST),
      .clear (1'b0),
      .inc   (w_miss),
      .count (wait_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_req_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_req_unit : directed self-checking bench for mem_req_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_req_unit;
   import cpu_types_pkg::*;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 3;

   logic              CLK = 1'b0;
   logic              RST;
   logic              dREN_i, dWEN_i, halt_i, hold_i, dhit;
   logic [WORD_W-1:0] addr_i, store_i, dmemload;
   logic              dmemREN, dmemWEN, mem_stall, halt_o;
   logic [WORD_W-1:0] dmemaddr, dmemstore, dload_o;
   logic [CNT_W-1:0]  wait_cnt;

   int compared = 0;
   int mismatched = 0;

   mem_req_unit #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
      .addr_i(addr_i), .store_i(store_i), .halt_i(halt_i), .hold_i(hold_i),
      .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dload_o(dload_o),
      .mem_stall(mem_stall), .halt_o(halt_o), .wait_cnt(wait_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      dREN_i = 0; dWEN_i = 0; halt_i = 0; hold_i = 0; dhit = 0;
      addr_i = '0; store_i = '0; dmemload = '0;
   endtask

   initial begin
      RST = 1;
      idle_inputs();
      tick(); tick();
      RST = 0;
      #1;
      chk("rst_wait_cnt", 64'(wait_cnt), 0);
      chk("rst_halt_o", 64'(halt_o), 0);
      chk("rst_dmemREN", 64'(dmemREN), 0);
      chk("rst_stall", 64'(mem_stall), 0);
      chk("rst_state", 64'(dut.r_state), 64'(IDLE));

      // 1: load with immediate hit
      tick();
      dREN_i = 1; addr_i = 32'h100; dhit = 1; dmemload = 32'hDEADBEEF;
      #1;
      chk("t1_dmemREN", 64'(dmemREN), 1);
      chk("t1_stall", 64'(mem_stall), 0);
      chk("t1_dload", 64'(dload_o), 64'hDEADBEEF);
      chk("t1_addr", 64'(dmemaddr), 64'h100);
      tick(); idle_inputs(); #1;
      chk("t1_wait_cnt", 64'(wait_cnt), 0);

      // 2: store with three miss cycles
      dWEN_i = 1; store_i = 32'h12345678; addr_i = 32'h200;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t2_stall_c%0d", i), 64'(mem_stall), 1);
         chk($sformatf("t2_wen_c%0d", i), 64'(dmemWEN), 1);
         tick();
      end
      dhit = 1; #1;
      chk("t2_stall_hit", 64'(mem_stall), 0);
      chk("t2_wen_hit", 64'(dmemWEN), 1);
      chk("t2_store", 64'(dmemstore), 64'h12345678);
      tick(); idle_inputs(); #1;
      chk("t2_wait_cnt", 64'(wait_cnt), 3);

      // 3: load hits while hold is high for 4 cycles
      dREN_i = 1; dhit = 1; hold_i = 1; dmemload = 32'hCAFE0001;
      #1;
      chk("t3_stall_hit", 64'(mem_stall), 1);
      chk("t3_dload_hit", 64'(dload_o), 64'hCAFE0001);
      tick();
      dhit = 0; dmemload = 32'h0BAD0BAD;
      for (int i = 1; i < 4; i++) begin
         #1;
         chk($sformatf("t3_state_c%0d", i), 64'(dut.r_state), 64'(DONE));
         chk($sformatf("t3_ren_c%0d", i), 64'(dmemREN), 0);
         chk($sformatf("t3_dload_c%0d", i), 64'(dload_o), 64'hCAFE0001);
         chk($sformatf("t3_stall_c%0d", i), 64'(mem_stall), 1);
         tick();
      end
      hold_i = 0; #1;
      chk("t3_stall_release", 64'(mem_stall), 0);
      chk("t3_ren_release", 64'(dmemREN), 0);
      tick(); idle_inputs(); #1;
      chk("t3_state_idle", 64'(dut.r_state), 64'(IDLE));
      chk("t3_wait_cnt", 64'(wait_cnt), 3);

      // 4: both enables high, store wins
      dREN_i = 1; dWEN_i = 1; #1;
      chk("t4_wen", 64'(dmemWEN), 1);
      chk("t4_ren", 64'(dmemREN), 0);
      dhit = 1;
      tick(); idle_inputs(); #1;

      // 5: halt arrives with a pending load
      dREN_i = 1; halt_i = 1;
      tick(); tick();
      dhit = 1; dmemload = 32'h00C0FFEE; #1;
      chk("t5_dload", 64'(dload_o), 64'h00C0FFEE);
      chk("t5_wait_cnt", 64'(wait_cnt), 5);
      tick();
      dREN_i = 0; dhit = 0; #1;
      chk("t5_state_pre", 64'(dut.r_state), 64'(IDLE));
      tick(); #1;
      chk("t5_state_halted", 64'(dut.r_state), 64'(HALTED));
      chk("t5_halt_early", 64'(halt_o), 0);
      tick();
      halt_i = 0; dREN_i = 1; #1;
      chk("t5_halt_o", 64'(halt_o), 1);
      chk("t5_ren_halted", 64'(dmemREN), 0);
      chk("t5_stall_halted", 64'(mem_stall), 0);
      tick(); tick(); #1;
      chk("t5_halt_sticky", 64'(halt_o), 1);

      // 6: reset in the middle of a miss
      RST = 1; idle_inputs(); tick(); RST = 0;
      dREN_i = 1; tick(); tick(); #1;
      chk("t6_wait_before", 64'(wait_cnt), 2);
      RST = 1; dREN_i = 0; #1;
      chk("t6_ren_in_rst", 64'(dmemREN), 0);
      tick(); RST = 0; #1;
      chk("t6_state", 64'(dut.r_state), 64'(IDLE));
      chk("t6_wait_cnt", 64'(wait_cnt), 0);
      chk("t6_halt_o", 64'(halt_o), 0);

      // Saturation: nine miss cycles on a 3-bit counter stop at 7
      dREN_i = 1;
      for (int i = 0; i < 9; i++) tick();
      #1;
      chk("sat_wait_cnt", 64'(wait_cnt), 7);
      dhit = 1; tick(); idle_inputs(); #1;
      chk("sat_hold_value", 64'(wait_cnt), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
